// File: rtl/packed_word_memory_if.sv
// Bus bundle for packed_word_memory: beat-write handshake, registered read
// port and word-complete notification.
interface packed_word_memory_if #(
    parameter int WORD_W = 64,
    parameter int IN_W   = 8,
    parameter int DEPTH  = 64
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = WORD_W / IN_W;
    localparam int CW    = $clog2(LANES + 1);

    // Handshake: a beat transfers on a rising edge where wrValid && wrReady.
    // wrReady may depend combinationally on wrAddr; wrValid must not depend on wrReady.
    logic              wrValid;
    logic              wrReady;
    logic [AW-1:0]     wrAddr;
    logic [IN_W-1:0]   wrData;

    logic              rdValid;
    logic              rdClear;
    logic [AW-1:0]     rdAddr;
    logic              rdDataValid;
    logic [WORD_W-1:0] rdData;
    logic [CW-1:0]     rdCount;

    logic              wordDone;
    logic [AW-1:0]     doneAddr;

    modport master (
        output wrValid, wrAddr, wrData, rdValid, rdClear, rdAddr,
        input  wrReady, rdDataValid, rdData, rdCount, wordDone, doneAddr
    );

    modport slave (
        input  wrValid, wrAddr, wrData, rdValid, rdClear, rdAddr,
        output wrReady, rdDataValid, rdData, rdCount, wordDone, doneAddr
    );
endinterface

// File: rtl/packed_word_memory.sv
// DEPTH entries of WORD_W bits, each filled by shifting in IN_W-bit beats,
// with per-entry fill counts, write-first registered reads and read-and-clear.
module packed_word_memory #(
    parameter int WORD_W    = 64,
    parameter int IN_W      = 8,
    parameter int DEPTH     = 64,
    parameter int OVERWRITE = 0
) (
    input  logic                 clk,
    input  logic                 resetN,
    packed_word_memory_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = WORD_W / IN_W;
    localparam int CW    = $clog2(LANES + 1);

    localparam logic [CW-1:0] FULL    = CW'(LANES);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    generate
        if ((WORD_W % IN_W) != 0 || DEPTH < 2) begin : g_bad_params
            $error("packed_word_memory: WORD_W must be a multiple of IN_W and DEPTH >= 2");
        end
    endgenerate

    logic [WORD_W-1:0] data_q [DEPTH];
    logic [CW-1:0]     cnt_q  [DEPTH];

    logic              wr_in_range, rd_in_range;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic [WORD_W-1:0] wr_old_data, wr_new_data;
    logic [CW-1:0]     wr_old_cnt, wr_new_cnt;
    logic              wr_full, wr_fire, wr_done;
    logic              rd_hit, rd_clr;
    logic [WORD_W-1:0] rd_word;
    logic [CW-1:0]     rd_cnt;

    // Out-of-range addresses are folded onto entry 0 for the array lookup only;
    // the in-range flags keep them from touching state.
    assign wr_in_range = {1'b0, bus.wrAddr} < DEPTH_L;
    assign rd_in_range = {1'b0, bus.rdAddr} < DEPTH_L;
    assign wr_idx      = wr_in_range ? bus.wrAddr : '0;
    assign rd_idx      = rd_in_range ? bus.rdAddr : '0;

    assign wr_old_data = data_q[wr_idx];
    assign wr_old_cnt  = cnt_q[wr_idx];
    assign wr_full     = (wr_old_cnt == FULL);
    assign wr_new_data = WORD_W'({wr_old_data, bus.wrData});
    assign wr_new_cnt  = wr_full ? FULL : (wr_old_cnt + ONE);

    assign bus.wrReady = resetN && (!wr_in_range || (OVERWRITE != 0) || !wr_full);
    assign wr_fire     = bus.wrValid && bus.wrReady && wr_in_range;
    assign wr_done     = wr_fire && (wr_old_cnt == (FULL - ONE));

    // Write-first: a same-cycle write to the read entry is visible in the result.
    assign rd_hit = wr_fire && (wr_idx == rd_idx);
    assign rd_clr = bus.rdValid && bus.rdClear && rd_in_range;

    always_comb begin
        rd_word = '0;
        rd_cnt  = '0;
        if (rd_in_range) begin
            if (rd_hit) begin
                rd_word = wr_new_data;
                rd_cnt  = wr_new_cnt;
            end else begin
                rd_word = data_q[rd_idx];
                rd_cnt  = cnt_q[rd_idx];
            end
        end
    end

    // A clear wins over a same-cycle write, so the new beat only leaves via the read.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_clr && (rd_idx == AW'(i))) begin
                    data_q[i] <= '0;
                    cnt_q[i]  <= '0;
                end else if (wr_fire && (wr_idx == AW'(i))) begin
                    data_q[i] <= wr_new_data;
                    cnt_q[i]  <= wr_new_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.rdDataValid <= 1'b0;
            bus.rdData      <= '0;
            bus.rdCount     <= '0;
            bus.wordDone    <= 1'b0;
            bus.doneAddr    <= '0;
        end else begin
            bus.rdDataValid <= bus.rdValid;
            if (bus.rdValid) begin
                bus.rdData  <= rd_word;
                bus.rdCount <= rd_cnt;
            end
            bus.wordDone <= wr_done;
            if (wr_done) begin
                bus.doneAddr <= bus.wrAddr;
            end
        end
    end
endmodule

// File: tb/tb_packed_word_memory.sv
// Drives a stall-policy and an overwrite-policy instance with shared stimulus
// and compares both against a per-entry beat-packing reference model.
module tb_packed_word_memory;
    localparam int WORD_W = 64;
    localparam int IN_W   = 8;
    localparam int DEPTH  = 48;
    localparam int LANES  = 8;

    // clock / reset
    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    logic       wr_valid, rd_valid, rd_clear;
    logic [5:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    packed_word_memory_if #(.WORD_W(WORD_W), .IN_W(IN_W), .DEPTH(DEPTH)) if0 ();
    packed_word_memory_if #(.WORD_W(WORD_W), .IN_W(IN_W), .DEPTH(DEPTH)) if1 ();

    assign if0.wrValid = wr_valid;  assign if1.wrValid = wr_valid;
    assign if0.wrAddr  = wr_addr;   assign if1.wrAddr  = wr_addr;
    assign if0.wrData  = wr_data;   assign if1.wrData  = wr_data;
    assign if0.rdValid = rd_valid;  assign if1.rdValid = rd_valid;
    assign if0.rdClear = rd_clear;  assign if1.rdClear = rd_clear;
    assign if0.rdAddr  = rd_addr;   assign if1.rdAddr  = rd_addr;

    packed_word_memory #(.WORD_W(WORD_W), .IN_W(IN_W), .DEPTH(DEPTH), .OVERWRITE(0)) u_stall (
        .clk(clk), .resetN(resetN), .bus(if0)
    );
    packed_word_memory #(.WORD_W(WORD_W), .IN_W(IN_W), .DEPTH(DEPTH), .OVERWRITE(1)) u_ovw (
        .clk(clk), .resetN(resetN), .bus(if1)
    );

    // scoreboard / reference model (index 0 = stall, 1 = overwrite)
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_data [2][DEPTH];
    int          m_cnt  [2][DEPTH];
    logic [67:0] exp_q [$];
    logic [67:0] last_rd   [2];
    logic        exp_vld   [2];
    logic        exp_done  [2];
    logic [5:0]  exp_daddr [2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[k][i] = '0;
                m_cnt[k][i]  = 0;
            end
            last_rd[k]   = '0;
            exp_vld[k]   = 1'b0;
            exp_done[k]  = 1'b0;
            exp_daddr[k] = '0;
        end
        exp_q.delete();
    endtask

    task automatic check_port(input int k, input logic rdv, input logic [63:0] rdd,
                              input logic [3:0] rdc, input logic wdn, input logic [5:0] dad);
        check($sformatf("rd_valid%0d", k), rdv, exp_vld[k]);
        if (exp_vld[k]) begin
            if (exp_q.size() == 0) check($sformatf("exp_q_empty%0d", k), 1, 0);
            else last_rd[k] = exp_q.pop_front();
        end
        check($sformatf("rd_data%0d", k), rdd, last_rd[k][63:0]);
        check($sformatf("rd_count%0d", k), rdc, last_rd[k][67:64]);
        check($sformatf("word_done%0d", k), wdn, exp_done[k]);
        if (exp_done[k]) check($sformatf("done_addr%0d", k), dad, exp_daddr[k]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy0"}, if0.wrReady, 0);     check({tag, "_rdy1"}, if1.wrReady, 0);
        check({tag, "_vld0"}, if0.rdDataValid, 0); check({tag, "_vld1"}, if1.rdDataValid, 0);
        check({tag, "_dat0"}, if0.rdData, 0);      check({tag, "_dat1"}, if1.rdData, 0);
        check({tag, "_cnt0"}, if0.rdCount, 0);     check({tag, "_cnt1"}, if1.rdCount, 0);
        check({tag, "_wd0"}, if0.wordDone, 0);     check({tag, "_wd1"}, if1.wordDone, 0);
        check({tag, "_da0"}, if0.doneAddr, 0);     check({tag, "_da1"}, if1.doneAddr, 0);
    endtask

    // driver: one clock cycle of stimulus, model update, and output checks
    task automatic do_cycle(input logic wv, input logic [5:0] wa, input logic [7:0] wd,
                            input logic rv, input logic rc, input logic [5:0] ra);
        logic        rdy, fire;
        logic [63:0] nd;
        int          nc;
        logic [67:0] word;
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_clear = rc; rd_addr = ra;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (wa >= DEPTH) rdy = 1'b1;
            else if (k == 1) rdy = 1'b1;
            else rdy = (m_cnt[k][wa] != LANES);
            check($sformatf("wr_ready%0d", k), (k == 0) ? if0.wrReady : if1.wrReady, rdy);
            fire = wv && rdy && (wa < DEPTH);
            exp_done[k] = 1'b0;
            nd = '0;
            nc = 0;
            if (fire) begin
                nd = (m_data[k][wa] << IN_W) | 64'(wd);
                nc = (m_cnt[k][wa] < LANES) ? m_cnt[k][wa] + 1 : LANES;
                exp_done[k]  = (m_cnt[k][wa] == LANES - 1);
                exp_daddr[k] = wa;
            end
            exp_vld[k] = rv;
            if (rv) begin
                if (ra >= DEPTH) word = '0;
                else if (fire && ra == wa) word = {4'(nc), nd};
                else word = {4'(m_cnt[k][ra]), m_data[k][ra]};
                exp_q.push_back(word);
            end
            if (fire) begin
                m_data[k][wa] = nd;
                m_cnt[k][wa]  = nc;
            end
            if (rv && rc && ra < DEPTH) begin
                m_data[k][ra] = '0;
                m_cnt[k][ra]  = 0;
            end
        end
        @(posedge clk);
        #1;
        check_port(0, if0.rdDataValid, if0.rdData, if0.rdCount, if0.wordDone, if0.doneAddr);
        check_port(1, if1.rdDataValid, if1.rdData, if1.rdCount, if1.wordDone, if1.doneAddr);
    endtask

    task automatic idle();
        do_cycle(1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic write(input logic [5:0] a, input logic [7:0] d);
        do_cycle(1'b1, a, d, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic read(input logic [5:0] a, input logic clr);
        do_cycle(1'b0, 6'd0, 8'h00, 1'b1, clr, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       wv, rv, rc;
        logic [5:0] wa, ra;
        logic [7:0] wd;

        resetN = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_clear = 1'b0; rd_addr = '0;
        model_reset();
        #1;
        check_all_zero("por");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // packing into entry 3
        for (int i = 1; i <= 8; i++) write(6'd3, 8'(i * 17));
        check("pack_done", if0.wordDone, 1);
        check("pack_daddr", if0.doneAddr, 3);
        read(6'd3, 1'b0);
        check("pack_data", if0.rdData, 64'h1122334455667788);
        check("pack_cnt", if0.rdCount, 8);

        // full entry: stall policy refuses, overwrite policy shifts out oldest
        write(6'd3, 8'h99);
        check("ovw_no_done", if1.wordDone, 0);
        read(6'd3, 1'b0);
        check("stall_unchanged", if0.rdData, 64'h1122334455667788);
        check("ovw_data", if1.rdData, 64'h2233445566778899);
        check("ovw_cnt", if1.rdCount, 8);

        // same-address write plus read-and-clear
        write(6'd7, 8'hAA);
        write(6'd7, 8'hBB);
        do_cycle(1'b1, 6'd7, 8'hCC, 1'b1, 1'b1, 6'd7);
        check("coll_data", if0.rdData, 64'h0000000000AABBCC);
        check("coll_cnt", if0.rdCount, 3);
        read(6'd7, 1'b0);
        check("coll_after", if1.rdCount, 0);

        // out-of-range address
        write(6'd50, 8'h5A);
        read(6'd50, 1'b0);
        check("oor_vld", if0.rdDataValid, 1);
        check("oor_data", if1.rdData, 0);

        // back-to-back reads then idle
        write(6'd1, 8'h01);
        write(6'd2, 8'h02);
        read(6'd1, 1'b0);
        read(6'd2, 1'b0);
        idle();
        check("hold_vld", if0.rdDataValid, 0);
        check("hold_data", if0.rdData, 64'h02);

        // asynchronous reset mid-write with live outputs
        for (int i = 0; i < 3; i++) write(6'd5, 8'(8'hE0 + i));
        for (int i = 0; i < 7; i++) write(6'd6, 8'(8'hD0 + i));
        do_cycle(1'b1, 6'd6, 8'hD7, 1'b1, 1'b0, 6'd5);
        check("pre_rst_done", if1.wordDone, 1);
        check("pre_rst_data", if1.rdData, 64'hE0E1E2);
        #2;
        resetN = 1'b0;
        #1;
        check_all_zero("arst");
        model_reset();
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0; rd_clear = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        read(6'd5, 1'b0);
        check("rst_cnt5", if0.rdCount, 0);
        read(6'd6, 1'b0);

        // randomized traffic over a small address window
        for (int n = 0; n < 600; n++) begin
            wv = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 9));
            wd = 8'($urandom_range(0, 255));
            rv = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 9));
            do_cycle(wv, wa, wd, rv, rc, ra);
        end
        idle();

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/packed_word_memory.md
Name: packed_word_memory

Overview:
- Parametrised successor to the 16-bit byte-shift memory used in the sparse matrix multiply datapath.
- Holds DEPTH entries, each WORD_W bits wide. Narrow IN_W-bit beats are shift-packed into each entry.
- Adds per-entry fill counters, a valid/ready write handshake, a selectable full-entry policy, registered reads with read-and-clear, and a word-complete notification.
- Sits between the element stream unpacker and the row/column operand fetch stage.

Parameters:
WORD_W, 64, bits per entry; must be an integer multiple of IN_W
IN_W, 8, bits per write beat
DEPTH, 64, number of entries; need not be a power of two
OVERWRITE, 0, full-entry policy: 0 = stall the writer, 1 = shift out the oldest beat
AW, $clog2(DEPTH), address width (derived)
LANES, WORD_W/IN_W, beats per full entry (derived)
CW, $clog2(LANES+1), fill-count width (derived)

Ports:
clk  input  1  clock, rising edge
resetN  input  1  asynchronous reset, active-low
wrValid  input  1  write beat offered
wrReady  output  1  write beat accepted this cycle when wrValid is also high
wrAddr  input  AW  target entry for the write
wrData  input  IN_W  write beat
rdValid  input  1  read request
rdClear  input  1  with rdValid: empty the entry after reading it
rdAddr  input  AW  read entry
rdDataValid  output  1  rdData and rdCount are valid
rdData  output  WORD_W  entry contents, oldest beat in the most significant occupied lane
rdCount  output  CW  number of beats held in the returned entry
wordDone  output  1  one-cycle pulse: an entry reached LANES beats
doneAddr  output  AW  entry that completed; valid when wordDone is high

Behaviour:
- Clock and reset: one clock, clk. resetN is asynchronous and active-low. Assertion immediately clears every entry's data and count and forces the following outputs to 0: rdData, rdCount, rdDataValid, wordDone, doneAddr, wrReady. Deassertion is synchronised externally. Any handshake in progress when reset asserts is discarded.
- Per-entry state: data[WORD_W] and count[CW], with count in 0..LANES.
- Write acceptance: a write fires when wrValid && wrReady. On the next edge, data <= {data[WORD_W-IN_W-1:0], wrData}.
  - If count < LANES, count increments by 1.
  - If count == LANES and OVERWRITE=1, count stays at LANES and the oldest beat is discarded.
- wrReady is combinational and is 0 while resetN is low. Otherwise:
  - OVERWRITE=1: wrReady = 1.
  - OVERWRITE=0: wrReady = (count[wrAddr] != LANES).
- wordDone: when an accepted write moves count from LANES-1 to LANES, wordDone = 1 and doneAddr = wrAddr on the following edge. wordDone is 0 in all other cycles. A write that overwrites an already-full entry does not pulse wordDone.
- Read latency is 1: a read requested in cycle N drives rdData, rdCount and rdDataValid=1 in cycle N+1. Without a new request, rdDataValid returns to 0 and rdData/rdCount hold their last values.
- Read and write to the same address in the same cycle: write-first. The read returns the contents with the new beat already applied, matching the legacy outData behaviour.
- Read-and-clear (rdValid && rdClear): the returned word is the write-first value. The entry is then data=0, count=0. A same-cycle write to that address is included in the returned word and is not retained in the entry.
- Out-of-range address (>= DEPTH):
  - Write: accepted with wrReady=1, then dropped; no state change and no wordDone.
  - Read: returns rdData=0, rdCount=0, rdDataValid=1.
- Independent reads and writes to different addresses proceed in the same cycle with no interaction.
- Elaboration: fails if WORD_W % IN_W != 0 or DEPTH < 2.

Test Plan:
- Reset: drive resetN low mid-write, with entry 5 holding 3 beats -> all outputs read 0 immediately. After release, reading entry 5 -> rdCount=0, rdData=0.
- Packing: write 0x11..0x88 to entry 3 -> wordDone=1 and doneAddr=3 one cycle after the 8th beat. A read then returns rdData=0x1122334455667788, rdCount=8.
- Full entry: OVERWRITE=0, write a 9th beat to full entry 3 -> wrReady=0 and the entry is unchanged. OVERWRITE=1, write 0x99 -> rdData=0x2233445566778899, rdCount=8, and no wordDone pulse.
- Same-address collision: entry 7 holds 0xAA,0xBB; in one cycle write 0xCC to 7 and read-and-clear 7 -> next cycle rdData=0x0000000000AABBCC, rdCount=3. A later read of 7 returns rdCount=0.
- Out-of-range access: DEPTH=48, write to address 50 -> wrReady=1 and no state change. A read of address 50 -> rdData=0, rdCount=0, rdDataValid=1.
- Latency and hold: issue back-to-back reads to entries 1 and 2, then idle -> rdDataValid is 1,1,0 across the three cycles, and rdData holds entry 2's value in the idle cycle.
